// File: rtl/ff_pkg.sv
// Shared mode encodings for the multimode flip-flop bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ff_pkg;

  localparam logic [1:0] FF_MODE_D  = 2'b00;
  localparam logic [1:0] FF_MODE_T  = 2'b01;
  localparam logic [1:0] FF_MODE_JK = 2'b10;
  localparam logic [1:0] FF_MODE_SR = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// One storage bit with D/T/JK/SR next-state logic and synchronous reset.
// Latency: 1 clk edge from inputs to q.
// Backpressure: none; en=0 holds q and suppresses illegal/change.
module ff_cell
  import ff_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       rst_val,
  output logic       q,
  output logic       illegal,
  output logic       change
);

  logic q_nxt;

  // Next-state decode for the selected mode; S=R=1 holds and raises illegal.
  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    case (mode)
      FF_MODE_D: q_nxt = a;
      FF_MODE_T: q_nxt = a ? ~q : q;
      FF_MODE_JK: begin
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      default: begin
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   illegal = 1'b1;
          default: q_nxt = q;
        endcase
      end
    endcase
    if (!en) begin
      q_nxt   = q;
      illegal = 1'b0;
    end
  end

  // Change indication feeds the bank-level chg register.
  assign change = q_nxt ^ q;

  // State register; reset wins over everything else on the edge.
  always_ff @(posedge clk) begin
    if (rst) q <= rst_val;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/ff_bank_multimode.sv
// WIDTH-bit flip-flop bank with run-time D/T/JK/SR mode, change and illegal-SR flags.
// Latency: 1 clk edge from inputs to out, chg and sr_err.
// Backpressure: none; en=0 holds out and clears chg/sr_err.
module ff_bank_multimode
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_n,
  output logic             chg,
  output logic             sr_err
);

  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] change;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .rst_val (RESET_VAL[i]),
      .q       (out[i]),
      .illegal (illegal[i]),
      .change  (change[i])
    );
  end

  assign out_n = ~out;

  // Bank-wide flags: any bit changed / any bit saw S=R=1 on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg    <= 1'b0;
      sr_err <= 1'b0;
    end else begin
      chg    <= |change;
      sr_err <= |illegal;
    end
  end

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Self-checking bench for ff_bank_multimode (WIDTH=4, RESET_VAL=4'b1010).
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_ff_bank_multimode;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b1010;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic [W-1:0] out, out_n;
  logic         chg, sr_err;

  int tests  = 0;
  int failed = 0;

  // Reference state
  logic [W-1:0] m_out = '0;
  logic         m_chg = 1'b0;
  logic         m_err = 1'b0;

  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .out    (out),
    .out_n  (out_n),
    .chg    (chg),
    .sr_err (sr_err)
  );

  always #5 clk = ~clk;

  // Characteristic equations of each flip-flop type, whole-vector.
  function automatic logic [W-1:0] ref_next(input logic [1:0] md, input logic [W-1:0] ia,
                                            input logic [W-1:0] ib, input logic [W-1:0] q);
    case (md)
      2'd0:    return ia;
      2'd1:    return q ^ ia;
      2'd2:    return (ia & ~q) | (~ib & q);
      default: return (ia & ~ib) | (q & (ia | ~ib));
    endcase
  endfunction

  // Advance one edge, update reference, then settle before sampling.
  task automatic tick();
    logic [W-1:0] nxt;
    @(posedge clk);
    if (rst) begin
      m_out = RV; m_chg = 1'b0; m_err = 1'b0;
    end else if (!en) begin
      m_chg = 1'b0; m_err = 1'b0;
    end else begin
      nxt   = ref_next(mode, a, b, m_out);
      m_chg = (nxt != m_out);
      m_err = (mode == 2'd3) && ((a & b) != '0);
      m_out = nxt;
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [W-1:0] ia, input logic [W-1:0] ib);
    rst = r; en = e; mode = md; a = ia; b = ib;
  endtask

  task automatic test_reset();
    drive(1, 1, 2'd1, 4'b1111, 4'b0000);
    tick();
    tests++; if (out !== 4'b1010) begin failed++; $display("FAIL reset_out got %b want 1010", out); end
    tests++; if (out_n !== 4'b0101) begin failed++; $display("FAIL reset_out_n got %b want 0101", out_n); end
    tests++; if (chg !== 1'b0) begin failed++; $display("FAIL reset_chg got %b want 0", chg); end
    tests++; if (sr_err !== 1'b0) begin failed++; $display("FAIL reset_sr_err got %b want 0", sr_err); end
  endtask

  task automatic test_d();
    drive(0, 1, 2'd0, 4'b0110, 4'b1111);
    tick();
    tests++; if (out !== 4'b0110) begin failed++; $display("FAIL d_out got %b want 0110", out); end
    tests++; if (chg !== 1'b1) begin failed++; $display("FAIL d_chg1 got %b want 1", chg); end
    tick();
    tests++; if (out !== 4'b0110) begin failed++; $display("FAIL d_out_rep got %b want 0110", out); end
    tests++; if (chg !== 1'b0) begin failed++; $display("FAIL d_chg_rep got %b want 0", chg); end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0011; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0011;
    drive(0, 1, 2'd0, 4'b0000, 4'b0000);
    tick();
    tests++; if (out !== 4'b0000) begin failed++; $display("FAIL t_pre got %b want 0000", out); end
    drive(0, 1, 2'd1, 4'b0011, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out !== exp_seq[i]) begin failed++; $display("FAIL t_out[%0d] got %b want %b", i, out, exp_seq[i]); end
      tests++; if (chg !== 1'b1) begin failed++; $display("FAIL t_chg[%0d] got %b want 1", i, chg); end
    end
  endtask

  task automatic test_jk();
    drive(1, 0, 2'd0, 4'b0000, 4'b0000);
    tick();
    drive(0, 1, 2'd2, 4'b1100, 4'b0110);
    tick();
    tests++; if (out !== 4'b1100) begin failed++; $display("FAIL jk_out got %b want 1100", out); end
    tests++; if (sr_err !== 1'b0) begin failed++; $display("FAIL jk_sr_err got %b want 0", sr_err); end
  endtask

  task automatic test_sr();
    drive(0, 1, 2'd0, 4'b0000, 4'b0000);
    tick();
    drive(0, 1, 2'd3, 4'b0011, 4'b0001);
    tick();
    tests++; if (out !== 4'b0010) begin failed++; $display("FAIL sr_out got %b want 0010", out); end
    tests++; if (sr_err !== 1'b1) begin failed++; $display("FAIL sr_err_set got %b want 1", sr_err); end
    drive(0, 1, 2'd3, 4'b0000, 4'b0000);
    tick();
    tests++; if (out !== 4'b0010) begin failed++; $display("FAIL sr_hold got %b want 0010", out); end
    tests++; if (sr_err !== 1'b0) begin failed++; $display("FAIL sr_err_clr got %b want 0", sr_err); end
  endtask

  task automatic test_enable_and_reset();
    logic [3:0] held;
    drive(0, 1, 2'd0, 4'b0101, 4'b0000);
    tick();
    held = 4'b0101;
    drive(0, 0, 2'd1, 4'b1111, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (out !== held) begin failed++; $display("FAIL en0_out[%0d] got %b want %b", i, out, held); end
      tests++; if (chg !== 1'b0) begin failed++; $display("FAIL en0_chg[%0d] got %b want 0", i, chg); end
    end
    drive(0, 1, 2'd1, 4'b1111, 4'b0000);
    tick();
    tests++; if (out !== 4'b1010) begin failed++; $display("FAIL toggle_on got %b want 1010", out); end
    drive(1, 1, 2'd1, 4'b1111, 4'b0000);
    tick();
    tests++; if (out !== 4'b1010) begin failed++; $display("FAIL rst_mid_out got %b want 1010", out); end
    tests++; if (chg !== 1'b0) begin failed++; $display("FAIL rst_mid_chg got %b want 0", chg); end
  endtask

  task automatic test_random();
    drive(1, 0, 2'd0, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      tick();
      tests++;
      if (out !== m_out || out_n !== ~m_out || chg !== m_chg || sr_err !== m_err) begin
        failed++;
        $display("FAIL rand[%0d] got out=%b out_n=%b chg=%b err=%b want out=%b out_n=%b chg=%b err=%b",
                 i, out, out_n, chg, sr_err, m_out, ~m_out, m_chg, m_err);
      end
    end
  endtask

  task automatic test_back_to_back_modes();
    drive(1, 0, 2'd0, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 2'(i % 4), 4'($urandom), 4'($urandom));
      tick();
      tests++;
      if (out !== m_out || chg !== m_chg || sr_err !== m_err) begin
        failed++;
        $display("FAIL b2b[%0d] mode=%0d got out=%b chg=%b err=%b want out=%b chg=%b err=%b",
                 i, mode, out, chg, sr_err, m_out, m_chg, m_err);
      end
    end
  endtask

  initial begin
    drive(1, 0, 2'd0, 4'b0000, 4'b0000);
    @(negedge clk);
    test_reset();
    test_d();
    test_toggle();
    test_jk();
    test_sr();
    test_enable_and_reset();
    test_random();
    test_back_to_back_modes();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
